// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the Execute stage: instruction codes, ALU
// function codes, status codes, condition-code bit positions and the
// multiplier FSM state encoding.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;
   localparam logic [3:0] ALU_MUL = 4'h4;

   localparam logic [1:0] STAT_AOK = 2'b00;
   localparam logic [1:0] STAT_HLT = 2'b01;
   localparam logic [1:0] STAT_ADR = 2'b10;
   localparam logic [1:0] STAT_INS = 2'b11;

   localparam logic [3:0] RNONE = 4'hF;

   // cc vector layout is {OF, SF, ZF}
   localparam int CC_ZF = 0;
   localparam int CC_SF = 1;
   localparam int CC_OF = 2;
   localparam logic [2:0] CC_RESET = 3'b001;

   typedef logic [1:0] mul_state_t;
   localparam mul_state_t MS_IDLE = 2'd0;
   localparam mul_state_t MS_MUL  = 2'd1;
   localparam mul_state_t MS_DONE = 2'd2;

endpackage

// File: rtl/y86_mul_seq.sv
// Sequential radix-2 shift-add multiplier. Produces the low DATA_W bits of
// the product, which are identical for signed and unsigned operands.
module y86_mul_seq
   import y86_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic              hold,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   mul_state_t        state;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] mplier;
   logic [DATA_W-1:0] acc;
   logic [CNT_W-1:0]  step_cnt;

   // FSM: load operands, run DATA_W shift-add steps, present the result once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= MS_IDLE;
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         step_cnt <= '0;
      end else begin
         case (state)
            MS_IDLE: begin
               if (start && !abort) begin
                  mcand    <= a;
                  mplier   <= b;
                  acc      <= '0;
                  step_cnt <= '0;
                  state    <= MS_MUL;
               end
            end
            MS_MUL: begin
               if (abort) begin
                  state <= MS_IDLE;
               end else begin
                  acc      <= acc + (mplier[0] ? mcand : '0);
                  mcand    <= mcand << 1;
                  mplier   <= mplier >> 1;
                  step_cnt <= step_cnt + 1'b1;
                  if (step_cnt == LAST_STEP) begin
                     state <= MS_DONE;
                  end
               end
            end
            MS_DONE: begin
               if (abort || !hold) begin
                  state <= MS_IDLE;
               end
            end
            default: state <= MS_IDLE;
         endcase
      end
   end

   // busy covers the accepting cycle so the pipeline stalls immediately
   always_comb begin
      busy    = (state == MS_MUL) || ((state == MS_IDLE) && start && !abort);
      done    = (state == MS_DONE);
      product = acc;
   end

endmodule

// File: rtl/exec_stage_pipe.sv
// Y86-64 Execute stage with ALU, condition codes, branch/cmov condition,
// optional sequential multiplier and the E/M pipeline register.
module exec_stage_pipe
   import y86_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter bit MUL_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              E_valid,
   input  logic [1:0]        E_stat,
   input  logic [3:0]        E_icode,
   input  logic [3:0]        E_ifun,
   input  logic [DATA_W-1:0] E_valA,
   input  logic [DATA_W-1:0] E_valB,
   input  logic [DATA_W-1:0] E_valC,
   input  logic [3:0]        E_dstE,
   input  logic [3:0]        E_dstM,
   input  logic              m_exc,
   input  logic              W_exc,
   input  logic              M_stall,
   input  logic              M_bubble,
   output logic              e_busy,
   output logic [DATA_W-1:0] e_valE,
   output logic [3:0]        e_dstE,
   output logic              M_valid,
   output logic [1:0]        M_stat,
   output logic [3:0]        M_icode,
   output logic              M_Cnd,
   output logic [DATA_W-1:0] M_valE,
   output logic [DATA_W-1:0] M_valA,
   output logic [3:0]        M_dstE,
   output logic [3:0]        M_dstM,
   output logic [2:0]        cc_out
);

   localparam logic [DATA_W-1:0] EIGHT = DATA_W'(8);

   logic              is_op;
   logic              is_mul;
   logic              op_illegal;
   logic              mul_start;
   logic              mul_busy;
   logic              mul_done;
   logic [DATA_W-1:0] mul_product;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic [DATA_W-1:0] alu_out;
   logic              alu_of;
   logic [2:0]        new_cc;
   logic              cnd;
   logic              cnd_out;
   logic              cc_update;

   // decode: a mulq is only legal when the multiplier is built in
   always_comb begin
      is_op      = (E_icode == I_OPQ);
      is_mul     = is_op && (E_ifun == ALU_MUL) && MUL_EN;
      op_illegal = is_op && ((E_ifun > ALU_MUL) || ((E_ifun == ALU_MUL) && !MUL_EN));
      mul_start  = E_valid && is_mul && !M_bubble;
   end

   y86_mul_seq #(.DATA_W(DATA_W)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .abort   (M_bubble),
      .hold    (M_stall),
      .a       (E_valB),
      .b       (E_valA),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // ALU result and signed overflow, selected by instruction class
   always_comb begin
      sum     = E_valB + E_valA;
      diff    = E_valB - E_valA;
      alu_out = '0;
      alu_of  = 1'b0;
      case (E_icode)
         I_OPQ: begin
            case (E_ifun)
               ALU_ADD: begin
                  alu_out = sum;
                  alu_of  = (E_valB[DATA_W-1] == E_valA[DATA_W-1]) && (sum[DATA_W-1] != E_valB[DATA_W-1]);
               end
               ALU_SUB: begin
                  alu_out = diff;
                  alu_of  = (E_valB[DATA_W-1] != E_valA[DATA_W-1]) && (diff[DATA_W-1] != E_valB[DATA_W-1]);
               end
               ALU_AND: alu_out = E_valB & E_valA;
               ALU_XOR: alu_out = E_valB ^ E_valA;
               ALU_MUL: alu_out = (is_mul && mul_done) ? mul_product : '0;
               default: alu_out = '0;
            endcase
         end
         I_RRMOVQ:         alu_out = E_valA;
         I_IRMOVQ:         alu_out = E_valC;
         I_RMMOVQ, I_MRMOVQ: alu_out = E_valB + E_valC;
         I_CALL, I_PUSHQ:  alu_out = E_valB - EIGHT;
         I_RET, I_POPQ:    alu_out = E_valB + EIGHT;
         default:          alu_out = '0;
      endcase
      new_cc = {alu_of, alu_out[DATA_W-1], (alu_out == '0)};
   end

   // condition evaluated against the flags left by the previous OPq
   always_comb begin
      case (E_ifun)
         4'd0:    cnd = 1'b1;
         4'd1:    cnd = (cc_out[CC_SF] ^ cc_out[CC_OF]) | cc_out[CC_ZF];
         4'd2:    cnd = cc_out[CC_SF] ^ cc_out[CC_OF];
         4'd3:    cnd = cc_out[CC_ZF];
         4'd4:    cnd = !cc_out[CC_ZF];
         4'd5:    cnd = !(cc_out[CC_SF] ^ cc_out[CC_OF]);
         4'd6:    cnd = !(cc_out[CC_SF] ^ cc_out[CC_OF]) && !cc_out[CC_ZF];
         default: cnd = 1'b0;
      endcase
      cnd_out   = ((E_icode == I_JXX) || (E_icode == I_RRMOVQ)) && cnd;
      e_dstE    = ((E_icode == I_RRMOVQ) && !cnd) ? RNONE : E_dstE;
      e_valE    = alu_out;
      e_busy    = mul_busy;
      cc_update = E_valid && is_op && !op_illegal && !m_exc && !W_exc
                  && !M_stall && !M_bubble && !mul_busy;
   end

   // condition-code register, written only when a committed OPq reaches M
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_out <= CC_RESET;
      end else if (cc_update) begin
         cc_out <= new_cc;
      end
   end

   // E/M register: bubble beats stall; a busy multiplier injects bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         M_valid <= 1'b0;
         M_stat  <= STAT_AOK;
         M_icode <= I_NOP;
         M_Cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else if (M_bubble || (!M_stall && mul_busy)) begin
         M_valid <= 1'b0;
         M_stat  <= STAT_AOK;
         M_icode <= I_NOP;
         M_Cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= RNONE;
         M_dstM  <= RNONE;
      end else if (!M_stall) begin
         M_valid <= E_valid;
         M_stat  <= op_illegal ? STAT_INS : E_stat;
         M_icode <= E_icode;
         M_Cnd   <= cnd_out;
         M_valE  <= alu_out;
         M_valA  <= E_valA;
         M_dstE  <= e_dstE;
         M_dstM  <= E_dstM;
      end
   end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Directed testbench for exec_stage_pipe: a 64-bit multiplier-enabled
// instance plus a 16-bit instance built without the multiplier.
module tb_exec_stage_pipe;
   import y86_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        E_valid = 1'b0;
   logic [1:0]  E_stat = 2'b00;
   logic [3:0]  E_icode = 4'h1;
   logic [3:0]  E_ifun = 4'h0;
   logic [63:0] E_valA = '0, E_valB = '0, E_valC = '0;
   logic [15:0] s_valA = '0, s_valB = '0, s_valC = '0;
   logic [3:0]  E_dstE = 4'hF, E_dstM = 4'hF;
   logic        m_exc = 1'b0, W_exc = 1'b0, M_stall = 1'b0, M_bubble = 1'b0;

   logic        e_busy, M_valid, M_Cnd;
   logic [63:0] e_valE, M_valE, M_valA;
   logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
   logic [1:0]  M_stat;
   logic [2:0]  cc_out;

   logic        e_busy_s, M_valid_s, M_Cnd_s;
   logic [15:0] e_valE_s, M_valE_s, M_valA_s;
   logic [3:0]  e_dstE_s, M_icode_s, M_dstE_s, M_dstM_s;
   logic [1:0]  M_stat_s;
   logic [2:0]  cc_out_s;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic [63:0] val;
      logic [2:0]  cc;
      logic [1:0]  stat;
   } alu_vec_t;

   exec_stage_pipe dut (
      .clk(clk), .rst_n(rst_n), .E_valid(E_valid), .E_stat(E_stat),
      .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB),
      .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM), .m_exc(m_exc),
      .W_exc(W_exc), .M_stall(M_stall), .M_bubble(M_bubble), .e_busy(e_busy),
      .e_valE(e_valE), .e_dstE(e_dstE), .M_valid(M_valid), .M_stat(M_stat),
      .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
      .M_dstE(M_dstE), .M_dstM(M_dstM), .cc_out(cc_out)
   );

   exec_stage_pipe #(.DATA_W(16), .MUL_EN(1'b0)) dut16 (
      .clk(clk), .rst_n(rst_n), .E_valid(E_valid), .E_stat(E_stat),
      .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(s_valA), .E_valB(s_valB),
      .E_valC(s_valC), .E_dstE(E_dstE), .E_dstM(E_dstM), .m_exc(m_exc),
      .W_exc(W_exc), .M_stall(M_stall), .M_bubble(M_bubble), .e_busy(e_busy_s),
      .e_valE(e_valE_s), .e_dstE(e_dstE_s), .M_valid(M_valid_s), .M_stat(M_stat_s),
      .M_icode(M_icode_s), .M_Cnd(M_Cnd_s), .M_valE(M_valE_s), .M_valA(M_valA_s),
      .M_dstE(M_dstE_s), .M_dstM(M_dstM_s), .cc_out(cc_out_s)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [3:0] dste);
      E_valid = 1'b1;
      E_stat  = STAT_AOK;
      E_icode = icode;
      E_ifun  = ifun;
      E_valA  = a;
      E_valB  = b;
      E_valC  = c;
      E_dstE  = dste;
      E_dstM  = 4'hF;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_exc = 1'b0; W_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
      set_e(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      #3;
      do_reset();
      rst_n = 1'b0;
      #1;
      total++; if (M_icode !== 4'h1) begin bad++; $display("[TB] FAIL reset_icode got=%h want=1", M_icode); end
      total++; if (M_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", M_valid); end
      total++; if (M_dstE !== 4'hF || M_dstM !== 4'hF) begin bad++; $display("[TB] FAIL reset_dst got=%h/%h want=F/F", M_dstE, M_dstM); end
      total++; if (cc_out !== 3'b001) begin bad++; $display("[TB] FAIL reset_cc got=%b want=001", cc_out); end
      total++; if (e_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", e_busy); end
      total++; if (M_stat !== STAT_AOK || M_Cnd !== 1'b0) begin bad++; $display("[TB] FAIL reset_stat_cnd got=%b/%b want=00/0", M_stat, M_Cnd); end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_add_overflow();
      do_reset();
      set_e(I_OPQ, ALU_ADD, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h2);
      total++; if (e_valE !== 64'h8000_0000_0000_0000) begin bad++; $display("[TB] FAIL add_e_valE got=%h want=8000000000000000", e_valE); end
      tick();
      total++; if (M_valE !== 64'h8000_0000_0000_0000) begin bad++; $display("[TB] FAIL add_M_valE got=%h want=8000000000000000", M_valE); end
      total++; if (cc_out !== 3'b110) begin bad++; $display("[TB] FAIL add_cc got=%b want=110", cc_out); end
      total++; if (M_icode !== I_OPQ || M_valid !== 1'b1 || M_dstE !== 4'h2) begin bad++; $display("[TB] FAIL add_fields got=%h/%b/%h want=6/1/2", M_icode, M_valid, M_dstE); end
      total++; if (M_valA !== 64'h1) begin bad++; $display("[TB] FAIL add_M_valA got=%h want=1", M_valA); end
      set_e(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
   endtask

   task automatic test_cond();
      set_e(I_OPQ, ALU_SUB, 64'd5, 64'd5, 64'h0, 4'h1);
      tick();
      total++; if (cc_out !== 3'b001) begin bad++; $display("[TB] FAIL sub_cc got=%b want=001", cc_out); end
      set_e(I_RRMOVQ, 4'h1, 64'h1234, 64'h0, 64'h0, 4'h3);
      total++; if (e_dstE !== 4'h3) begin bad++; $display("[TB] FAIL cmovle_taken_e_dstE got=%h want=3", e_dstE); end
      tick();
      total++; if (M_Cnd !== 1'b1 || M_valE !== 64'h1234 || M_dstE !== 4'h3) begin bad++; $display("[TB] FAIL cmovle_taken_M got=%b/%h/%h want=1/1234/3", M_Cnd, M_valE, M_dstE); end
      total++; if (cc_out !== 3'b001) begin bad++; $display("[TB] FAIL cmov_no_cc got=%b want=001", cc_out); end
      set_e(I_OPQ, ALU_ADD, 64'd1, 64'd1, 64'h0, 4'h1);
      tick();
      total++; if (cc_out !== 3'b000) begin bad++; $display("[TB] FAIL add11_cc got=%b want=000", cc_out); end
      set_e(I_RRMOVQ, 4'h1, 64'h1234, 64'h0, 64'h0, 4'h3);
      total++; if (e_dstE !== 4'hF) begin bad++; $display("[TB] FAIL cmovle_not_taken_e_dstE got=%h want=F", e_dstE); end
      tick();
      total++; if (M_Cnd !== 1'b0 || M_dstE !== 4'hF) begin bad++; $display("[TB] FAIL cmovle_not_taken_M got=%b/%h want=0/F", M_Cnd, M_dstE); end
      set_e(I_JXX, 4'h4, 64'h0, 64'h0, 64'h0, 4'hF);
      tick();
      total++; if (M_Cnd !== 1'b1) begin bad++; $display("[TB] FAIL jne_cnd got=%b want=1", M_Cnd); end
      set_e(I_JXX, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF);
      tick();
      total++; if (M_Cnd !== 1'b0) begin bad++; $display("[TB] FAIL jl_cnd got=%b want=0", M_Cnd); end
      set_e(I_IRMOVQ, 4'h0, 64'h0, 64'h0, 64'h55, 4'h4);
      tick();
      total++; if (M_Cnd !== 1'b0) begin bad++; $display("[TB] FAIL irmovq_cnd got=%b want=0", M_Cnd); end
   endtask

   task automatic test_alu_ops();
      alu_vec_t v[10];
      do_reset();
      v[0] = '{I_OPQ,    ALU_AND, 64'hFF00, 64'hF0F0, 64'h0, 64'hF000, 3'b000, STAT_AOK};
      v[1] = '{I_OPQ,    ALU_XOR, 64'hFF, 64'hFF, 64'h0, 64'h0, 3'b001, STAT_AOK};
      v[2] = '{I_IRMOVQ, 4'h0, 64'h0, 64'h0, 64'hABCD, 64'hABCD, 3'b001, STAT_AOK};
      v[3] = '{I_OPQ,    ALU_SUB, 64'd5, 64'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 3'b010, STAT_AOK};
      v[4] = '{I_OPQ,    ALU_SUB, 64'd1, 64'h8000_0000_0000_0000, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100, STAT_AOK};
      v[5] = '{I_MRMOVQ, 4'h0, 64'h0, 64'h100, 64'h20, 64'h120, 3'b100, STAT_AOK};
      v[6] = '{I_POPQ,   4'h0, 64'h0, 64'h100, 64'h0, 64'h108, 3'b100, STAT_AOK};
      v[7] = '{I_CALL,   4'h0, 64'h0, 64'h100, 64'h0, 64'hF8, 3'b100, STAT_AOK};
      v[8] = '{I_HALT,   4'h0, 64'h7, 64'h9, 64'h3, 64'h0, 3'b100, STAT_AOK};
      v[9] = '{I_OPQ,    4'h5, 64'd5, 64'd5, 64'h0, 64'h0, 3'b100, STAT_INS};
      for (int i = 0; i < 10; i++) begin
         set_e(v[i].icode, v[i].ifun, v[i].a, v[i].b, v[i].c, 4'h6);
         total++; if (e_valE !== v[i].val) begin bad++; $display("[TB] FAIL alu%0d_e_valE got=%h want=%h", i, e_valE, v[i].val); end
         tick();
         total++; if (M_valE !== v[i].val || M_stat !== v[i].stat) begin bad++; $display("[TB] FAIL alu%0d_M got=%h/%b want=%h/%b", i, M_valE, M_stat, v[i].val, v[i].stat); end
         total++; if (cc_out !== v[i].cc) begin bad++; $display("[TB] FAIL alu%0d_cc got=%b want=%b", i, cc_out, v[i].cc); end
      end
   endtask

   task automatic test_exc_stall_bubble();
      do_reset();
      m_exc = 1'b1;
      set_e(I_OPQ, ALU_ADD, 64'd4, 64'd3, 64'h0, 4'h2);
      tick();
      total++; if (M_valE !== 64'd7 || cc_out !== 3'b001) begin bad++; $display("[TB] FAIL m_exc got=%h/%b want=7/001", M_valE, cc_out); end
      m_exc = 1'b0; W_exc = 1'b1;
      set_e(I_OPQ, ALU_ADD, 64'h10, 64'h10, 64'h0, 4'h2);
      tick();
      total++; if (M_valE !== 64'h20 || cc_out !== 3'b001) begin bad++; $display("[TB] FAIL W_exc got=%h/%b want=20/001", M_valE, cc_out); end
      W_exc = 1'b0; M_stall = 1'b1;
      set_e(I_OPQ, ALU_ADD, 64'd1, 64'd2, 64'h0, 4'h5);
      tick();
      total++; if (M_valE !== 64'h20 || M_dstE !== 4'h2 || cc_out !== 3'b001) begin bad++; $display("[TB] FAIL stall_hold got=%h/%h/%b want=20/2/001", M_valE, M_dstE, cc_out); end
      M_bubble = 1'b1;
      tick();
      total++; if (M_icode !== 4'h1 || M_valid !== 1'b0 || M_dstE !== 4'hF || M_dstM !== 4'hF) begin bad++; $display("[TB] FAIL bubble_nop got=%h/%b/%h/%h want=1/0/F/F", M_icode, M_valid, M_dstE, M_dstM); end
      total++; if (cc_out !== 3'b001) begin bad++; $display("[TB] FAIL bubble_cc got=%b want=001", cc_out); end
      M_bubble = 1'b0; M_stall = 1'b0;
   endtask

   task automatic test_mul();
      int busy_cycles;
      do_reset();
      set_e(I_OPQ, ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'h0, 4'h5);
      total++; if (e_busy !== 1'b1) begin bad++; $display("[TB] FAIL mul_busy_first got=%b want=1", e_busy); end
      busy_cycles = 0;
      while (e_busy === 1'b1 && busy_cycles < 200) begin
         busy_cycles++;
         tick();
      end
      total++; if (busy_cycles !== 65) begin bad++; $display("[TB] FAIL mul_busy_len got=%0d want=65", busy_cycles); end
      total++; if (e_valE !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("[TB] FAIL mul_e_valE got=%h want=ffffffffffffffeb", e_valE); end
      total++; if (M_icode !== 4'h1 || M_valid !== 1'b0) begin bad++; $display("[TB] FAIL mul_bubbles got=%h/%b want=1/0", M_icode, M_valid); end
      tick();
      set_e(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
      total++; if (M_valE !== 64'hFFFF_FFFF_FFFF_FFEB || M_dstE !== 4'h5 || M_icode !== I_OPQ) begin bad++; $display("[TB] FAIL mul_M got=%h/%h/%h want=ffffffffffffffeb/5/6", M_valE, M_dstE, M_icode); end
      total++; if (cc_out !== 3'b010) begin bad++; $display("[TB] FAIL mul_cc got=%b want=010", cc_out); end
      total++; if (e_busy !== 1'b0) begin bad++; $display("[TB] FAIL mul_idle_after got=%b want=0", e_busy); end
   endtask

   task automatic test_mul_abort();
      do_reset();
      set_e(I_OPQ, ALU_MUL, 64'd2, 64'd3, 64'h0, 4'h5);
      repeat (10) tick();
      total++; if (e_busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_busy_before got=%b want=1", e_busy); end
      M_bubble = 1'b1;
      set_e(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
      tick();
      M_bubble = 1'b0;
      #1;
      total++; if (e_busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy_after got=%b want=0", e_busy); end
      total++; if (M_icode !== 4'h1 || M_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_nop got=%h/%b want=1/0", M_icode, M_valid); end
      repeat (70) tick();
      total++; if (e_busy !== 1'b0 || M_valE !== 64'h0 || cc_out !== 3'b001) begin bad++; $display("[TB] FAIL abort_quiet got=%b/%h/%b want=0/0/001", e_busy, M_valE, cc_out); end
   endtask

   task automatic test_reset_mid_mul();
      do_reset();
      set_e(I_OPQ, ALU_ADD, 64'd1, 64'd1, 64'h0, 4'h1);
      tick();
      set_e(I_OPQ, ALU_MUL, 64'd9, 64'd9, 64'h0, 4'h5);
      repeat (5) tick();
      rst_n = 1'b0;
      set_e(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
      total++; if (e_busy !== 1'b0 || cc_out !== 3'b001) begin bad++; $display("[TB] FAIL rst_mid_mul got=%b/%b want=0/001", e_busy, cc_out); end
      total++; if (M_icode !== 4'h1 || M_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_mul_M got=%h/%b want=1/0", M_icode, M_valid); end
      tick();
      rst_n = 1'b1;
      repeat (70) tick();
      total++; if (e_busy !== 1'b0 || M_valE !== 64'h0) begin bad++; $display("[TB] FAIL rst_mid_mul_idle got=%b/%h want=0/0", e_busy, M_valE); end
   endtask

   task automatic test_w16();
      do_reset();
      s_valB = 16'h0010; s_valA = 16'h0; s_valC = 16'h0;
      set_e(I_PUSHQ, 4'h0, 64'h0, 64'h10, 64'h0, 4'h4);
      total++; if (e_valE_s !== 16'h0008) begin bad++; $display("[TB] FAIL w16_push_e_valE got=%h want=0008", e_valE_s); end
      tick();
      total++; if (M_valE_s !== 16'h0008) begin bad++; $display("[TB] FAIL w16_push_M got=%h want=0008", M_valE_s); end
      s_valA = 16'd2; s_valB = 16'd3;
      set_e(I_OPQ, ALU_MUL, 64'd2, 64'd3, 64'h0, 4'h5);
      total++; if (e_busy_s !== 1'b0) begin bad++; $display("[TB] FAIL w16_mul_busy got=%b want=0", e_busy_s); end
      tick();
      total++; if (M_stat_s !== STAT_INS || M_valE_s !== 16'h0 || cc_out_s !== 3'b001) begin bad++; $display("[TB] FAIL w16_mul_ins got=%b/%h/%b want=11/0000/001", M_stat_s, M_valE_s, cc_out_s); end
      set_e(I_NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_cond();
      test_alu_ops();
      test_exc_stall_bubble();
      test_mul();
      test_mul_abort();
      test_reset_mid_mul();
      test_w16();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
